alien_bomb_scheduler: RTL

//   Shares a fixed pool of NUM_BOMBS alien bomb slots between COLUMNS alien-column requesters.

---
 rtl/invaders_pkg.sv | 29 ++
 rtl/alien_bomb_scheduler_if.sv | 23 ++
 rtl/alien_bomb_scheduler_arbiter.sv | 31 +++
 rtl/alien_bomb_scheduler.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared types for the alien bomb scheduler.
// Slot record, FSM encoding and LFSR helper.
package invaders_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SELECT
  } bomb_state_t;

  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } bomb_slot_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0);
  endfunction

endpackage

// File: rtl/alien_bomb_scheduler_if.sv
// Column request / launch grant bundle.
// master = alien columns, slave = scheduler.
interface alien_bomb_scheduler_if #(
  parameter int COLUMNS = 8
);
  import invaders_pkg::*;

  logic [COLUMNS-1:0]         col_req;
  logic [COLUMNS*COORD_W-1:0] col_x;
  logic [COLUMNS*COORD_W-1:0] col_y;
  logic [COLUMNS-1:0]         fire_grant;

  modport master (
    output col_req, col_x, col_y,
    input  fire_grant
  );

  modport slave (
    input  col_req, col_x, col_y,
    output fire_grant
  );

endinterface

// File: rtl/alien_bomb_scheduler_arbiter.sv
// Round-robin arbiter: first set req at or after
// start_ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    k         = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(start_ptr) + i) % N;
      if (!any && req[k]) begin
        any       = 1'b1;
        grant_idx = IW'(k);
        grant[k]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alien_bomb_scheduler.sv
// Alien bomb pool: per-frame move, retire and one launch.
// Define BOMB_RAND_EN to randomise the arbitration start.
module alien_bomb_scheduler
  import invaders_pkg::*;
#(
  parameter int COLUMNS       = 8,
  parameter int NUM_BOMBS     = 3,
  parameter int BOMB_SPEED    = 3,
  parameter int LOWER_BORDER  = 470,
  parameter int FIRE_INTERVAL = 20,
  parameter int SCALING       = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         frame_tick,
  alien_bomb_scheduler_if.slave        cols,
  input  logic [NUM_BOMBS-1:0]         bomb_hit,
  input  logic [COORD_W-1:0]           hpos,
  input  logic [COORD_W-1:0]           vpos,
  output logic [NUM_BOMBS-1:0]         bomb_active,
  output logic [NUM_BOMBS*COORD_W-1:0] bomb_x,
  output logic [NUM_BOMBS*COORD_W-1:0] bomb_y,
  output logic                         busy,
  output logic                         bomb_gfx
);

  localparam int IW = $clog2(COLUMNS);
  localparam int SW = (NUM_BOMBS > 1) ?
                      $clog2(NUM_BOMBS) : 1;
  localparam int CW = (FIRE_INTERVAL > 0) ?
                      $clog2(FIRE_INTERVAL + 1) : 1;
  localparam int YW = COORD_W + 1;

  bomb_state_t        state;
  bomb_slot_t         slot [NUM_BOMBS];
  logic [CW-1:0]      cooldown;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      start_ptr;
  logic [COLUMNS-1:0] grant_oh;
  logic [COLUMNS-1:0] fire_grant_q;
  logic [IW-1:0]      grant_idx;
  logic               any_req;
  logic               free_any;
  logic [SW-1:0]      free_idx;
  logic               launch;
  logic [COORD_W-1:0] launch_x;
  logic [COORD_W-1:0] launch_y;
  logic [YW-1:0]      moved_y [NUM_BOMBS];

`ifdef BOMB_RAND_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
    end else if (frame_tick) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign start_ptr = IW'((32'(rr_ptr) +
                     32'(lfsr[3:0])) % COLUMNS);
`else
  assign start_ptr = rr_ptr;
`endif

  rr_arbiter #(
    .N (COLUMNS),
    .IW(IW)
  ) u_arb (
    .req      (cols.col_req),
    .start_ptr(start_ptr),
    .grant    (grant_oh),
    .grant_idx(grant_idx),
    .any      (any_req)
  );

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
      if (!slot[i].active) begin
        free_any = 1'b1;
        free_idx = SW'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BOMBS; i++) begin
      moved_y[i] = {1'b0, slot[i].y} + YW'(BOMB_SPEED);
    end
  end

  assign launch = (state == SELECT) &&
                  (cooldown == '0) &&
                  free_any && any_req;

  assign launch_x =
    cols.col_x[int'(grant_idx)*COORD_W +: COORD_W];
  assign launch_y =
    cols.col_y[int'(grant_idx)*COORD_W +: COORD_W];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cooldown     <= '0;
      rr_ptr       <= '0;
      fire_grant_q <= '0;
      for (int i = 0; i < NUM_BOMBS; i++) begin
        slot[i] <= '0;
      end
    end else begin
      fire_grant_q <= '0;
      unique case (state)
        IDLE: begin
          if (frame_tick) state <= MOVE;
        end
        MOVE: begin
          state <= SELECT;
          if (cooldown != '0) cooldown <= cooldown - CW'(1);
          for (int i = 0; i < NUM_BOMBS; i++) begin
            if (slot[i].active) begin
              if (moved_y[i] > YW'(LOWER_BORDER))
                slot[i] <= '0;
              else
                slot[i].y <= moved_y[i][COORD_W-1:0];
            end
          end
        end
        SELECT: begin
          state <= IDLE;
          if (launch) begin
            slot[free_idx] <= '{active: 1'b1,
                                x: launch_x,
                                y: launch_y};
            fire_grant_q <= grant_oh;
            rr_ptr <= (grant_idx == IW'(COLUMNS - 1)) ?
                      '0 : grant_idx + IW'(1);
            cooldown <= CW'(FIRE_INTERVAL);
          end
        end
        default: state <= IDLE;
      endcase
      // Hits override the move; the slot being loaded is exempt
      for (int i = 0; i < NUM_BOMBS; i++) begin
        if (bomb_hit[i] &&
            !(launch && free_idx == SW'(i))) begin
          slot[i] <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_out
    assign bomb_active[g]              = slot[g].active;
    assign bomb_x[g*COORD_W +: COORD_W] = slot[g].x;
    assign bomb_y[g*COORD_W +: COORD_W] = slot[g].y;
  end

  assign busy            = (state != IDLE);
  assign cols.fire_grant = fire_grant_q;

  always_comb begin
    bomb_gfx = 1'b0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (slot[i].active &&
          {1'b0, hpos} >= {1'b0, slot[i].x} &&
          {1'b0, hpos} <  {1'b0, slot[i].x} + YW'(SCALING) &&
          {1'b0, vpos} >= {1'b0, slot[i].y} &&
          {1'b0, vpos} <  {1'b0, slot[i].y} + YW'(3*SCALING))
        bomb_gfx = 1'b1;
    end
  end

endmodule
